uart_csr_fifo_regs: RTL and testbench

//  Parametrised UART CSR block: memory-mapped baud/control/status/data registers with
//  TX and RX FIFOs between the CPU CSR bus and the UART serialiser/deserialiser.

---
 rtl/uart_csr_fifo_regs.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_csr_fifo_regs.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr_fifo_regs.sv
// Module file: uart_csr_fifo_regs (top) plus its private FIFO, uart_csr_fifo.
// Top ports: CPU CSR bus (csr_addr/csr_wr/csr_rd/csr_wdata -> csr_rdata/csr_rvalid),
//   UART config (baud_div, tx_en, rx_en, parity_en, parity_odd), TX stream
//   (tx_data/tx_valid/tx_ready), RX strobe (rx_data/rx_valid/rx_parity_err) and irq.
// Optional feature macro: UART_CSR_IRQ_EN (IRQ_MASK register and registered irq output).
// Clocking: single clk, synchronous active-high rst.

// Synchronous FIFO with flush, count-based full/empty, push accepted when full if a pop lands in the same cycle.
// Latency: pushed data is visible at pop_dat the cycle after the push; pop_dat is the live head.
// Backpressure: none exported; the caller reads full/empty. Pushes to a full FIFO without a pop are dropped.
module uart_csr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // A pop frees the slot this cycle, so a push into a full FIFO is still taken.
    assign do_pop  = pop_vld & ~empty;
    assign do_push = push_vld & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// UART CSR register block: baud/control/status/data/levels registers fronting TX and RX FIFOs.
// Latency: csr_rdata/csr_rvalid exactly one cycle after csr_rd; irq one cycle after a status change.
// Backpressure: TX drains on tx_valid&tx_ready; RX has none, so full RX drops and flags rx_overflow.
module uart_csr_fifo_regs #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int BAUD_W   = 16,
    parameter int BAUD_RST = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        csr_addr,
    input  logic              csr_wr,
    input  logic              csr_rd,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    output logic              csr_rvalid,
    output logic [BAUD_W-1:0] baud_div,
    output logic              tx_en,
    output logic              rx_en,
    output logic              parity_en,
    output logic              parity_odd,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_parity_err,
    output logic              irq
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    localparam logic [2:0] A_BAUD   = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_SEND   = 3'd3;
    localparam logic [2:0] A_READ   = 3'd4;
    localparam logic [2:0] A_MASK   = 3'd5;
    localparam logic [2:0] A_LEVELS = 3'd6;

    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        ctrl_q, ctrl_d;      // {parity_odd, parity_en, rx_en, tx_en}
    logic [2:0]        sticky_q, sticky_d;  // {parity_err, tx_overflow, rx_overflow}
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic              rd_en;
    logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [TX_CW-1:0]  tx_count;
    logic [RX_CW-1:0]  rx_count;
    logic [DATA_W-1:0] rx_head;
    logic [2:0]        sticky_set;
    logic [6:0]        status;
    logic [6:0]        irq_mask_rd;
    logic [31:0]       rd_mux;
    logic [31:0]       levels;

    // A simultaneous write and read is treated as a write only.
    assign rd_en = csr_rd & ~csr_wr;

    assign tx_push  = csr_wr & (csr_addr == A_SEND);
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_flush = csr_wr & (csr_addr == A_CTRL) & csr_wdata[4];
    assign rx_push  = rx_valid & ctrl_q[1];
    assign rx_pop   = rd_en & (csr_addr == A_READ);
    assign rx_flush = csr_wr & (csr_addr == A_CTRL) & csr_wdata[5];

    uart_csr_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (tx_flush),
        .push_vld (tx_push),
        .push_dat (csr_wdata[DATA_W-1:0]),
        .pop_vld  (tx_pop),
        .pop_dat  (tx_data),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    uart_csr_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (rx_flush),
        .push_vld (rx_push),
        .push_dat (rx_data),
        .pop_vld  (rx_pop),
        .pop_dat  (rx_head),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign tx_valid   = ~tx_empty & ctrl_q[0];
    assign baud_div   = baud_q;
    assign tx_en      = ctrl_q[0];
    assign rx_en      = ctrl_q[1];
    assign parity_en  = ctrl_q[2];
    assign parity_odd = ctrl_q[3];
    assign csr_rdata  = rdata_q;
    assign csr_rvalid = rvalid_q;

    assign status = {sticky_q, rx_empty, rx_full, tx_empty, tx_full};

    // Overflow only when full with no same-cycle pop to make room.
    assign sticky_set = {rx_push & rx_parity_err,
                         tx_push & tx_full & ~tx_pop,
                         rx_push & rx_full & ~rx_pop};

    always_comb begin
        levels                = '0;
        levels[TX_CW-1:0]     = tx_count;
        levels[16 +: RX_CW]   = rx_count;
    end

    always_comb begin
        rd_mux = '0;
        case (csr_addr)
            A_BAUD:   rd_mux = 32'(baud_q);
            A_CTRL:   rd_mux = 32'(ctrl_q);
            A_STATUS: rd_mux = 32'(status);
            A_READ:   rd_mux = rx_empty ? 32'd0 : 32'(rx_head);
            A_MASK:   rd_mux = 32'(irq_mask_rd);
            A_LEVELS: rd_mux = levels;
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        baud_d   = baud_q;
        ctrl_d   = ctrl_q;
        sticky_d = sticky_q | sticky_set;
        if (csr_wr) begin
            case (csr_addr)
                A_BAUD:   baud_d   = csr_wdata[BAUD_W-1:0];
                A_CTRL:   ctrl_d   = csr_wdata[3:0];
                // Write-one-clears; a set in the same cycle takes priority.
                A_STATUS: sticky_d = (sticky_q & ~csr_wdata[6:4]) | sticky_set;
                default:  ;
            endcase
        end
        rvalid_d = rd_en;
        rdata_d  = rd_en ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q   <= BAUD_W'(BAUD_RST);
            ctrl_q   <= '0;
            sticky_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            ctrl_q   <= ctrl_d;
            sticky_q <= sticky_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef UART_CSR_IRQ_EN
    logic [6:0] irq_mask_q, irq_mask_d;
    logic       irq_q, irq_d;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (csr_wr && (csr_addr == A_MASK)) begin
            irq_mask_d = csr_wdata[6:0];
        end
        irq_d = |(status & irq_mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_mask_rd = irq_mask_q;
    assign irq         = irq_q;
`else
    assign irq_mask_rd = '0;
    assign irq         = 1'b0;
`endif
endmodule

// File: tb/tb_uart_csr_fifo_regs.sv
// Directed bench for uart_csr_fifo_regs: CSR reads and TX characters are checked
// against scoreboard queues filled when the stimulus is driven.
module tb_uart_csr_fifo_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  csr_addr = '0;
    logic        csr_wr = 1'b0;
    logic        csr_rd = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic [15:0] baud_div;
    logic        tx_en, rx_en, parity_en, parity_odd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_parity_err = 1'b0;
    logic        irq;

`ifdef UART_CSR_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    uart_csr_fifo_regs dut (
        .clk           (clk),
        .rst           (rst),
        .csr_addr      (csr_addr),
        .csr_wr        (csr_wr),
        .csr_rd        (csr_rd),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_rvalid    (csr_rvalid),
        .baud_div      (baud_div),
        .tx_en         (tx_en),
        .rx_en         (rx_en),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [2:0] addr, input logic [31:0] data);
        csr_addr  = addr;
        csr_wdata = data;
        csr_wr    = 1'b1;
        tick();
        csr_wr    = 1'b0;
    endtask

    // Expected data is queued at issue; the response is popped when rvalid shows.
    task automatic csr_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        logic        got;
        logic [31:0] e;
        rd_q.push_back(exp);
        csr_addr = addr;
        csr_rd   = 1'b1;
        tick();
        csr_rd   = 1'b0;
        got = csr_rvalid;
        for (int n = 0; n < 3 && !got; n++) begin
            tick();
            got = csr_rvalid;
        end
        chk({tag, "_rvalid"}, 32'(got), 32'd1);
        e = rd_q.pop_front();
        chk(tag, csr_rdata, e);
    endtask

    task automatic drain_tx(input string tag);
        int n = 0;
        tx_ready = 1'b1;
        while (tx_q.size() > 0 && n < 60) begin
            if (tx_valid) chk(tag, 32'(tx_data), 32'(tx_q.pop_front()));
            tick();
            n++;
        end
        tx_ready = 1'b0;
        chk({tag, "_left"}, 32'(tx_q.size()), 32'd0);
    endtask

    task automatic rx_strobe(input logic [7:0] d, input logic perr);
        rx_data       = d;
        rx_valid      = 1'b1;
        rx_parity_err = perr;
        tick();
        rx_valid      = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    initial begin
        // Reset values
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_baud", 32'(baud_div), 32'd434);
        chk("rst_txvalid", 32'(tx_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rvalid", 32'(csr_rvalid), 32'd0);
        chk("rst_rdata", csr_rdata, 32'd0);
        chk("rst_ctrl_out", 32'({parity_odd, parity_en, rx_en, tx_en}), 32'd0);
        csr_read("baud_rst", 3'd0, 32'd434);
        tick();
        chk("rvalid_pulse", 32'(csr_rvalid), 32'd0);
        csr_read("status_rst", 3'd2, 32'h0A);
        csr_read("reserved", 3'd7, 32'd0);
        csr_read("mask_rst", 3'd5, 32'd0);

        // Baud register and write-wins-over-read
        csr_write(3'd0, 32'h1234_5678);
        chk("baud_out", 32'(baud_div), 32'h5678);
        csr_read("baud_rb", 3'd0, 32'h5678);
        csr_rd = 1'b1;
        csr_write(3'd0, 32'h0000_00AB);
        csr_rd = 1'b0;
        chk("rdwr_no_rvalid", 32'(csr_rvalid), 32'd0);
        chk("rdwr_baud", 32'(baud_div), 32'hAB);

        // TX ordering
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(8'h41 + 8'(i));
            csr_write(3'd3, 32'hFFFF_FF41 + 32'(i));
        end
        chk("txen0_hold", 32'(tx_valid), 32'd0);
        csr_read("levels_tx3", 3'd6, 32'd3);
        csr_write(3'd1, 32'h1);
        drain_tx("tx_abc");
        csr_read("status_tx_empty", 3'd2, 32'h0A);
        csr_write(3'd1, 32'h0);

        // TX overflow with tx_en=0
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_q.push_back(8'h10 + 8'(i));
            csr_write(3'd3, 32'h10 + 32'(i));
        end
        chk("txfull_hold", 32'(tx_valid), 32'd0);
        csr_read("levels_tx16", 3'd6, 32'h10);
        csr_read("status_txovf", 3'd2, 32'h29);
        csr_write(3'd2, 32'h20);
        csr_read("status_w1c", 3'd2, 32'h09);

        // Full TX with simultaneous pop and push
        csr_write(3'd1, 32'h1);
        chk("tx_valid_on", 32'(tx_valid), 32'd1);
        chk("tx_head_pushpop", 32'(tx_data), 32'(tx_q.pop_front()));
        tx_q.push_back(8'h99);
        tx_ready = 1'b1;
        csr_write(3'd3, 32'h99);
        tx_ready = 1'b0;
        csr_read("levels_pushpop", 3'd6, 32'h10);
        csr_read("status_no_ovf", 3'd2, 32'h09);
        drain_tx("tx_full_drain");
        csr_write(3'd1, 32'h0);

        // RX disabled ignores strobes
        rx_strobe(8'h77, 1'b0);
        csr_read("rx_ignored", 3'd6, 32'd0);

        // RX fill, then push + pop on full
        csr_write(3'd1, 32'h2);
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(8'h80 + 8'(i));
            rx_strobe(8'h80 + 8'(i), 1'b0);
        end
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        csr_read("rx_pop_on_full", 3'd4, 32'(rx_q.pop_front()));
        rx_valid = 1'b0;
        rx_q.push_back(8'hAA);
        csr_read("status_rxfull", 3'd2, 32'h06);
        csr_read("levels_rx16", 3'd6, 32'h0010_0000);
        for (int i = 0; i < 16; i++) csr_read("rx_data", 3'd4, 32'(rx_q.pop_front()));
        csr_read("rx_empty_read", 3'd4, 32'd0);
        csr_read("status_rx_drained", 3'd2, 32'h0A);

        // Parity error and irq
        csr_write(3'd5, 32'h40);
        csr_read("mask_rb", 3'd5, IRQ_ON ? 32'h40 : 32'h0);
        rx_strobe(8'h55, 1'b1);
        chk("irq_not_yet", 32'(irq), 32'd0);
        tick();
        chk("irq_parity", 32'(irq), 32'(IRQ_ON));
        csr_read("status_parity", 3'd2, 32'h42);
        csr_write(3'd2, 32'h40);
        csr_read("status_parity_clr", 3'd2, 32'h02);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Parity control outputs, then flush
        csr_write(3'd1, 32'h0E);
        chk("parity_outs", 32'({parity_odd, parity_en, rx_en}), 32'h7);
        for (int i = 0; i < 4; i++) rx_strobe(8'h60 + 8'(i), 1'b0);
        csr_read("levels_rx5", 3'd6, 32'h0005_0000);
        csr_write(3'd1, 32'h23);
        csr_read("status_flush", 3'd2, 32'h0A);
        csr_read("ctrl_flush_rb", 3'd1, 32'h03);
        csr_read("levels_flush", 3'd6, 32'd0);
        rx_q.delete();

        // RX overflow
        for (int i = 0; i < 17; i++) rx_strobe(8'(i), 1'b0);
        csr_read("status_rxovf", 3'd2, 32'h16);
        csr_read("levels_rxovf", 3'd6, 32'h0010_0000);

        // Reset mid-transfer
        csr_write(3'd3, 32'h5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_baud", 32'(baud_div), 32'd434);
        chk("rst2_ctrl", 32'({parity_odd, parity_en, rx_en, tx_en}), 32'd0);
        csr_read("rst2_status", 3'd2, 32'h0A);
        csr_read("rst2_levels", 3'd6, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
